// File: rtl/id_ex_stage_if.sv
// ----------------------------------------------------------------------------
// id_ex_stage_if
//   Bundle of signals between the decode stage (register file, pipeline
//   control) and the ID/EX pipeline register.
//
//   ID side  : id_ctrl, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
//              id_imm, id_pc, flush
//   EX side  : ex_ctrl, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
//              ex_imm, ex_pc
//   Status   : stall (combinational), halted (registered, sticky)
//
//   Control word packing (10 bits, MSB first):
//     {alu_src, mem_to_reg, reg_write, mem_read, mem_write,
//      alu_operation[2:0], branch, halt}
//
//   master : drives the ID side and flush (decode stage / testbench)
//   slave  : the pipeline register itself
// ----------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int XLEN = 64
);
    logic [9:0]      id_ctrl;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_pc;
    logic            flush;

    logic [9:0]      ex_ctrl;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_pc;
    logic            stall;
    logic            halted;

    modport master (
        output id_ctrl, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_pc, flush,
        input  ex_ctrl, ex_rs1, ex_rs2, ex_rd,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, stall, halted
    );

    modport slave (
        input  id_ctrl, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_pc, flush,
        output ex_ctrl, ex_rs1, ex_rs2, ex_rd,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, stall, halted
    );
endinterface

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of the 5-stage RISC-V core. Captures the decoded
//   control word, register indices, operands, immediate and PC; inserts a
//   bubble on load-use hazards and branch flushes; sequences the HALT drain
//   so EX/MEM/WB can retire before the core reports halted.
//
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      id_ex_stage_if.slave (ID inputs, EX outputs, stall, halted)
//
//   Parameters:
//     XLEN          datapath width of operand, immediate and PC fields
//     DRAIN_CYCLES  cycles after HALT enters EX before halted asserts
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN         = 64,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    id_ex_stage_if.slave bus
);
    localparam int MEM_READ_BIT = 6;
    localparam int HALT_BIT     = 0;
    localparam int CNT_W        = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    // What the EX register loads on the next edge.
    typedef enum logic [1:0] {CAP_INSTR, CAP_BUBBLE, CAP_HALT} cap_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    cap_t             cap;
    logic             load_use;

    // Hazard is judged on the instruction already in EX against the one in ID.
    assign load_use = bus.ex_ctrl[MEM_READ_BIT] && (bus.ex_rd != 5'd0) &&
                      ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));

    // A flush kills the ID instruction, so a pending load-use hold is moot.
    assign bus.stall  = ((state == RUN) && load_use && !bus.flush) ||
                        (state == DRAIN) || (state == HALTED);
    assign bus.halted = (state == HALTED);

    // ------------------------------------------------------------------
    // Next state, drain counter and capture selection
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a value unassigned, which would infer a latch.
        state_next = state;
        cnt_next   = cnt;
        cap        = CAP_BUBBLE;

        if (bus.flush) begin
            // Flush beats everything; during a drain it also cancels the halt.
            if (state == DRAIN) begin
                state_next = RUN;
                cnt_next   = '0;
            end
        end else begin
            unique case (state)
                DRAIN: begin
                    if (cnt == CNT_LAST) state_next = HALTED;
                    else                 cnt_next   = cnt + 1'b1;
                end
                HALTED: ;
                default: begin  // RUN
                    if (load_use) begin
                        cap = CAP_BUBBLE;
                    end else if (bus.id_ctrl[HALT_BIT]) begin
                        cap        = CAP_HALT;
                        state_next = DRAIN;
                        cnt_next   = '0;
                    end else begin
                        cap = CAP_INSTR;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: these are individual flops, not a memory array, so all of
            // them are reset; outputs must read zero straight out of reset.
            bus.ex_ctrl     <= '0;
            bus.ex_rs1      <= '0;
            bus.ex_rs2      <= '0;
            bus.ex_rd       <= '0;
            bus.ex_rs1_data <= {XLEN{1'b0}};
            bus.ex_rs2_data <= {XLEN{1'b0}};
            bus.ex_imm      <= {XLEN{1'b0}};
            bus.ex_pc       <= {XLEN{1'b0}};
        end else begin
            unique case (cap)
                CAP_INSTR: begin
                    bus.ex_ctrl     <= bus.id_ctrl;
                    bus.ex_rs1      <= bus.id_rs1;
                    bus.ex_rs2      <= bus.id_rs2;
                    bus.ex_rd       <= bus.id_rd;
                    bus.ex_rs1_data <= bus.id_rs1_data;
                    bus.ex_rs2_data <= bus.id_rs2_data;
                    bus.ex_imm      <= bus.id_imm;
                    bus.ex_pc       <= bus.id_pc;
                end
                CAP_HALT: begin
                    // Decoder leaves the other HALT fields stale; pass only the flag.
                    bus.ex_ctrl <= 10'h001;
                    bus.ex_rs1  <= '0;
                    bus.ex_rs2  <= '0;
                    bus.ex_rd   <= '0;
                end
                default: begin  // CAP_BUBBLE: data fields keep their last value
                    bus.ex_ctrl <= '0;
                    bus.ex_rs1  <= '0;
                    bus.ex_rs2  <= '0;
                    bus.ex_rd   <= '0;
                end
            endcase
        end
    end
endmodule
